// File: rtl/cpu_icache.sv
// cpu_icache: direct-mapped read-only instruction cache with single-beat line refill.
module cpu_icache #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             req_valid,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic                             flush,
  output logic                             stall,
  output logic                             resp_valid,
  output logic [WORD_WIDTH-1:0]            resp_word,
  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic [ADDR_WIDTH-1:0]            mem_req_addr,
  input  logic                             mem_resp_valid,
  input  logic [WORD_WIDTH*LINE_WORDS-1:0] mem_resp_line
);
  localparam int OB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(NUM_LINES);
  localparam int AW = ADDR_WIDTH - 2;
  localparam int TW = AW - OB - IB;
  localparam int LW = WORD_WIDTH * LINE_WORDS;
  typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT} state_t;
  state_t                state_q, state_d;
  logic [AW-1:0]         miss_q, miss_d;
  logic                  pend_q, pend_d;
  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [WORD_WIDTH-1:0] resp_word_q, resp_word_d;
  logic [TW-1:0]         tag_q [NUM_LINES];
  logic [LW-1:0]         data_q [NUM_LINES];
  logic [OB-1:0]         req_off, miss_off;
  logic [IB-1:0]         req_idx, miss_idx;
  logic [TW-1:0]         req_tag, miss_tag;
  logic                  hit, fill, unused_bits;
  assign req_off     = req_addr[OB+1:2];
  assign req_idx     = req_addr[OB+IB+1:OB+2];
  assign req_tag     = req_addr[ADDR_WIDTH-1:OB+IB+2];
  assign miss_off    = miss_q[OB-1:0];
  assign miss_idx    = miss_q[OB+IB-1:OB];
  assign miss_tag    = miss_q[AW-1:OB+IB];
  assign unused_bits = ^req_addr[1:0];
  assign hit  = req_valid && valid_q[req_idx] && tag_q[req_idx] == req_tag;
  assign fill = state_q == MISS_WAIT && mem_resp_valid;
  assign mem_req_valid = state_q == MISS_REQ;
  assign mem_req_addr  = mem_req_valid ? {miss_q[AW-1:OB], (OB+2)'(0)} : '0;
  assign resp_valid    = resp_valid_q;
  assign resp_word     = resp_word_q;
  always_comb begin
    state_d      = state_q;
    miss_d       = miss_q;
    valid_d      = valid_q;
    resp_valid_d = 1'b0;
    resp_word_d  = resp_word_q;
    pend_d       = state_q != IDLE && (pend_q || flush);
    stall        = 1'b0;
    case (state_q)
      IDLE: begin
        stall = req_valid && !hit;
        if (hit) begin
          resp_valid_d = 1'b1;
          resp_word_d  = data_q[req_idx][WORD_WIDTH*int'(req_off) +: WORD_WIDTH];
        end else if (req_valid) begin
          miss_d  = req_addr[ADDR_WIDTH-1:2];
          state_d = MISS_REQ;
        end
      end
      MISS_REQ: begin
        stall   = 1'b1;
        state_d = mem_req_ready ? MISS_WAIT : MISS_REQ;
      end
      MISS_WAIT: begin
        stall = !mem_resp_valid;
        if (mem_resp_valid) begin
          resp_valid_d      = 1'b1;
          resp_word_d       = mem_resp_line[WORD_WIDTH*int'(miss_off) +: WORD_WIDTH];
          valid_d[miss_idx] = !(pend_q || flush);
          pend_d            = 1'b0;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) valid_d = '0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      miss_q       <= '0;
      pend_q       <= 1'b0;
      valid_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_word_q  <= '0;
    end else begin
      state_q      <= state_d;
      miss_q       <= miss_d;
      pend_q       <= pend_d;
      valid_q      <= valid_d;
      resp_valid_q <= resp_valid_d;
      resp_word_q  <= resp_word_d;
    end
  end
  // Arrays carry no reset; only the valid bits gate their use.
  always_ff @(posedge clock) begin
    if (fill && !reset) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= mem_resp_line;
    end
  end
endmodule
